// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, GF(2^8) helpers and MixColumns FSM state type
package aes_pkg;

  localparam int AES_BYTES = 16;
  localparam int AES_COLS  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mixcol_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Column index arithmetic wraps at four columns.
  function automatic logic [1:0] col_at(input logic [1:0] base, input int offs);
    logic [31:0] o;
    o = offs;
    return base + o[1:0];
  endfunction

  // Column c holds bytes c, c+4, c+8, c+12; byte k sits at [127-8k -: 8].
  function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
    logic [31:0] col;
    col = '0;
    for (int r = 0; r < 4; r++) begin
      col[31-8*r -: 8] = s[127-8*(int'(c)+4*r) -: 8];
    end
    return col;
  endfunction

  function automatic logic [127:0] put_col(input logic [127:0] s, input logic [1:0] c,
                                           input logic [31:0] col);
    logic [127:0] o;
    o = s;
    for (int r = 0; r < 4; r++) begin
      o[127-8*(int'(c)+4*r) -: 8] = col[31-8*r -: 8];
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_mixcol_unit.sv
// rtl/aes_mixcol_unit.sv - combinational single-column MixColumns / InvMixColumns transform
// Inverse coefficients exist only when AES_MIXCOL_INV_EN is defined.
module aes_mixcol_unit
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  logic [7:0] a0, a1, a2, a3;
  logic [31:0] fwd_col;

  assign {a0, a1, a2, a3} = col_in;

  assign fwd_col = {gf_mul2(a0) ^ gf_mul3(a1) ^ a2          ^ a3,
                    a0          ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3,
                    a0          ^ a1          ^ gf_mul2(a2) ^ gf_mul3(a3),
                    gf_mul3(a0) ^ a1          ^ a2          ^ gf_mul2(a3)};

`ifdef AES_MIXCOL_INV_EN
  logic [31:0] inv_col;

  assign inv_col = {gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3),
                    gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3),
                    gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3),
                    gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3)};

  assign col_out = inv ? inv_col : fwd_col;
`else
  logic unused_inv;

  assign unused_inv = inv;
  assign col_out    = fwd_col;
`endif

endmodule

// File: rtl/aes_mixcol_engine.sv
// rtl/aes_mixcol_engine.sv - iterative handshaked AES MixColumns engine, COLS_PER_CYCLE columns per cycle
// Define AES_MIXCOL_INV_EN to build InvMixColumns support selected by inv_mode.
module aes_mixcol_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         final_round,
  input  logic         inv_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  localparam int NCYC = AES_COLS / COLS_PER_CYCLE;

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("aes_mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  mixcol_state_e fsm;
  logic [1:0]    col_idx;
  logic [127:0]  state_q;
  logic          bypass_q;
  logic          mode_q;
  logic [127:0]  state_mixed;
  logic          last_group;

  logic [31:0] unit_in  [COLS_PER_CYCLE];
  logic [31:0] unit_out [COLS_PER_CYCLE];

  for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_unit
    assign unit_in[gi] = get_col(state_q, col_at(col_idx, gi));

    aes_mixcol_unit u_unit (
      .col_in  (unit_in[gi]),
      .inv     (mode_q),
      .col_out (unit_out[gi])
    );
  end

  always_comb begin
    state_mixed = state_q;
    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
      state_mixed = put_col(state_mixed, col_at(col_idx, i), unit_out[i]);
    end
  end

  assign last_group = (col_idx == 2'((NCYC - 1) * COLS_PER_CYCLE));
  assign state_out  = state_q;

`ifndef AES_MIXCOL_INV_EN
  logic unused_inv_mode;

  assign unused_inv_mode = inv_mode;
  assign mode_q          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      col_idx   <= 2'd0;
      state_q   <= '0;
      bypass_q  <= 1'b0;
`ifdef AES_MIXCOL_INV_EN
      mode_q    <= 1'b0;
`endif
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            state_q  <= state_in;
            bypass_q <= final_round;
`ifdef AES_MIXCOL_INV_EN
            mode_q   <= inv_mode;
`endif
            col_idx  <= 2'd0;
            in_ready <= 1'b0;
            fsm      <= BUSY;
          end
        end
        BUSY: begin
          // A final-round block spends one cycle here untouched, giving latency 1.
          if (bypass_q) begin
            fsm       <= DONE;
            out_valid <= 1'b1;
          end else begin
            state_q <= state_mixed;
            col_idx <= col_idx + 2'(COLS_PER_CYCLE);
            if (last_group) begin
              fsm       <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: begin
          fsm       <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule
